alpha_ramp_ctrl: RTL and testbench

- Sequencer for the alpha (smoothing coefficient) input of the low-pass filter chain.
- Accepts a new target alpha via a load pulse and ramps the applied alpha from its current value to the target in bounded steps at a programmable rate.
- After reaching the target, waits a programmable settle time, then flags the filter output as valid.
- Prevents step discontinuities in filter dynamics during live retuning from the register bank.

---
 rtl/alpha_ctrl_pkg.sv | 21 ++
 rtl/ramp_tick_gen.sv | 44 ++++
 rtl/alpha_ramp_ctrl.sv | 154 +++++++++++++++
 tb/tb_alpha_ramp_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alpha_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alpha_ctrl_pkg
// Description : Shared types and default widths for the alpha ramp sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alpha_ctrl_pkg;

  localparam int unsigned c_ALPHA_WIDTH_DEF  = 32;
  localparam int unsigned c_RATE_WIDTH_DEF   = 16;
  localparam int unsigned c_SETTLE_WIDTH_DEF = 24;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ramp_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : ramp_tick_gen
// Description : Reloadable down-counter prescaler. While enabled, produces a
//               one-cycle update strobe each time the count sits at zero and
//               reloads itself from reload_val_i on that strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ramp_tick_gen
  import alpha_ctrl_pkg::*;
#(
  parameter int unsigned RATE_WIDTH = c_RATE_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reload_i,
  input  logic [RATE_WIDTH-1:0] reload_val_i,
  input  logic                  en_i,
  output logic                  tick_o
);

  logic [RATE_WIDTH-1:0] cnt_q;

  // Strobe is taken straight from the registered count so the update lands
  // on the same edge the count would otherwise wrap.
  assign tick_o = en_i && (cnt_q == '0);

  // Down-count while enabled, reload on explicit request or on the strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (reload_i) begin
      cnt_q <= reload_val_i;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_q <= reload_val_i;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alpha_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alpha_ramp_ctrl
// Description : Ramps the applied filter alpha toward a loaded target in
//               bounded steps at a programmable rate, waits a settle time,
//               then flags the filter output as settled.
//               Optional macro ALPHA_RAMP_FLUSH_EN: an immediate-jump load
//               (step 0) also pulses flt_rst_o for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alpha_ramp_ctrl
  import alpha_ctrl_pkg::*;
#(
  parameter int unsigned ALPHA_WIDTH  = c_ALPHA_WIDTH_DEF,
  parameter int unsigned RATE_WIDTH   = c_RATE_WIDTH_DEF,
  parameter int unsigned SETTLE_WIDTH = c_SETTLE_WIDTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [ALPHA_WIDTH-1:0]  target_i,
  input  logic [ALPHA_WIDTH-1:0]  step_i,
  input  logic [RATE_WIDTH-1:0]   rate_i,
  input  logic [SETTLE_WIDTH-1:0] settle_i,
  output logic [ALPHA_WIDTH-1:0]  alpha_o,
  output logic                    busy_o,
  output logic                    settled_o,
  output logic                    flt_rst_o
);

  state_e                  state_q;
  logic [ALPHA_WIDTH-1:0]  alpha_q;
  logic [ALPHA_WIDTH-1:0]  target_q;
  logic [ALPHA_WIDTH-1:0]  step_q;
  logic [RATE_WIDTH-1:0]   rate_q;
  logic [SETTLE_WIDTH-1:0] settle_q;
  logic [SETTLE_WIDTH-1:0] settle_cnt_q;
  logic                    busy_q;
  logic                    settled_q;

  logic                    w_tick;
  logic                    w_up;
  logic [ALPHA_WIDTH-1:0]  w_diff;
  logic                    w_step_zero;
  logic                    w_presc_reload;
  logic [RATE_WIDTH-1:0]   w_presc_val;
  logic                    w_presc_en;

  // Magnitude of the remaining distance; no wrap in either direction
  assign w_up   = (target_q > alpha_q);
  assign w_diff = w_up ? (target_q - alpha_q) : (alpha_q - target_q);

  assign w_step_zero = (step_i == '0);

  // A load takes the fresh rate; the strobe-driven reload uses the latched one.
  // The prescaler is frozen on a load cycle so a load always wins over an update.
  assign w_presc_reload = load_i && !w_step_zero;
  assign w_presc_val    = load_i ? rate_i : rate_q;
  assign w_presc_en     = (state_q == ST_RAMP) && !load_i;

  ramp_tick_gen #(
    .RATE_WIDTH (RATE_WIDTH)
  ) u_tick (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .reload_i     (w_presc_reload),
    .reload_val_i (w_presc_val),
    .en_i         (w_presc_en),
    .tick_o       (w_tick)
  );

`ifdef ALPHA_RAMP_FLUSH_EN
  logic flt_rst_q;
`endif

  // Sequencer FSM with registered outputs; load has priority in every state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      alpha_q      <= '0;
      target_q     <= '0;
      step_q       <= '0;
      rate_q       <= '0;
      settle_q     <= '0;
      settle_cnt_q <= '0;
      busy_q       <= 1'b0;
      settled_q    <= 1'b0;
`ifdef ALPHA_RAMP_FLUSH_EN
      flt_rst_q    <= 1'b0;
`endif
    end else begin
`ifdef ALPHA_RAMP_FLUSH_EN
      flt_rst_q <= 1'b0;
`endif
      if (load_i) begin
        target_q  <= target_i;
        step_q    <= step_i;
        rate_q    <= rate_i;
        settle_q  <= settle_i;
        busy_q    <= 1'b1;
        settled_q <= 1'b0;
        if (w_step_zero) begin
          alpha_q      <= target_i;
          settle_cnt_q <= settle_i;
          state_q      <= ST_SETTLE;
`ifdef ALPHA_RAMP_FLUSH_EN
          flt_rst_q    <= 1'b1;
`endif
        end else begin
          state_q <= ST_RAMP;
        end
      end else begin
        case (state_q)
          ST_RAMP: begin
            if (w_tick) begin
              if (w_diff <= step_q) begin
                alpha_q      <= target_q;
                settle_cnt_q <= settle_q;
                state_q      <= ST_SETTLE;
              end else if (w_up) begin
                alpha_q <= alpha_q + step_q;
              end else begin
                alpha_q <= alpha_q - step_q;
              end
            end
          end
          ST_SETTLE: begin
            if (settle_cnt_q != '0) begin
              settle_cnt_q <= settle_cnt_q - 1'b1;
            end else begin
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
              settled_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign alpha_o   = alpha_q;
  assign busy_o    = busy_q;
  assign settled_o = settled_q;
`ifdef ALPHA_RAMP_FLUSH_EN
  assign flt_rst_o = flt_rst_q;
`else
  assign flt_rst_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alpha_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alpha_ramp_ctrl
// Description : Self-checking bench for alpha_ramp_ctrl: vector table,
//               directed corner sequences, and random loads against a
//               schedule-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alpha_ramp_ctrl;

`ifdef ALPHA_RAMP_FLUSH_EN
  localparam logic c_FLUSH = 1'b1;
`else
  localparam logic c_FLUSH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        load_i;
  logic [31:0] target_i;
  logic [31:0] step_i;
  logic [15:0] rate_i;
  logic [23:0] settle_i;
  logic [31:0] alpha_o;
  logic        busy_o;
  logic        settled_o;
  logic        flt_rst_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alpha_ramp_ctrl dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .load_i    (load_i),
    .target_i  (target_i),
    .step_i    (step_i),
    .rate_i    (rate_i),
    .settle_i  (settle_i),
    .alpha_o   (alpha_o),
    .busy_o    (busy_o),
    .settled_o (settled_o),
    .flt_rst_o (flt_rst_o)
  );

  typedef struct {
    logic        ld;
    logic [31:0] tgt;
    logic [31:0] stp;
    logic [15:0] rate;
    logic [23:0] settle;
    logic [31:0] ea;
    logic        eb;
    logic        es;
    logic        ef;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic        b;
    logic        s;
    logic        f;
  } exp_t;

  vec_t vecs[25];
  exp_t sched[$];
  logic [31:0] m_a;
  logic        m_b, m_s, m_f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] a, input logic b, input logic s, input logic f);
    chk({tag, ".alpha"},   alpha_o,   a);
    chk({tag, ".busy"},    {31'd0, busy_o},    {31'd0, b});
    chk({tag, ".settled"}, {31'd0, settled_o}, {31'd0, s});
    chk({tag, ".flt_rst"}, {31'd0, flt_rst_o}, {31'd0, f});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [31:0] t, input logic [31:0] s,
                       input logic [15:0] r, input logic [23:0] st);
    load_i = ld; target_i = t; step_i = s; rate_i = r; settle_i = st;
  endtask

  task automatic set_vec(input int i, input logic ld, input logic [31:0] t, input logic [31:0] s,
                         input logic [15:0] r, input logic [23:0] st,
                         input logic [31:0] ea, input logic eb, input logic es, input logic ef);
    vecs[i] = '{ld, t, s, r, st, ea, eb, es, ef};
  endtask

  // Reference model: on each load, lay out the whole future output trajectory
  // edge by edge from the current alpha; otherwise replay it, then hold.
  task automatic model_edge(input logic ld, input logic [31:0] t, input logic [31:0] s,
                            input logic [15:0] r, input logic [23:0] st);
    exp_t e;
    logic [31:0] cur, d;
    bit done;
    if (ld) begin
      sched.delete();
      if (s == 0) begin
        sched.push_back('{t, 1'b1, 1'b0, c_FLUSH});
      end else begin
        cur = m_a;
        sched.push_back('{cur, 1'b1, 1'b0, 1'b0});
        done = 0;
        while (!done) begin
          for (int k = 0; k < int'(r); k++) sched.push_back('{cur, 1'b1, 1'b0, 1'b0});
          d = (t > cur) ? t - cur : cur - t;
          if (d <= s) begin
            cur = t;
            done = 1;
          end else if (t > cur) begin
            cur = cur + s;
          end else begin
            cur = cur - s;
          end
          sched.push_back('{cur, 1'b1, 1'b0, 1'b0});
        end
      end
      for (int k = 0; k < int'(st); k++) sched.push_back('{t, 1'b1, 1'b0, 1'b0});
      sched.push_back('{t, 1'b0, 1'b1, 1'b0});
    end
    if (sched.size() > 0) begin
      e = sched.pop_front();
      m_a = e.a; m_b = e.b; m_s = e.s; m_f = e.f;
    end else begin
      m_f = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] t, s, d;
    logic [15:0] r;
    logic [23:0] st;
    logic        ld;

    // Upward ramp from reset
    set_vec(0,  1, 100, 30, 0, 3, 0,   1, 0, 0);
    set_vec(1,  0, 0, 0, 0, 0,    30,  1, 0, 0);
    set_vec(2,  0, 0, 0, 0, 0,    60,  1, 0, 0);
    set_vec(3,  0, 0, 0, 0, 0,    90,  1, 0, 0);
    set_vec(4,  0, 0, 0, 0, 0,    100, 1, 0, 0);
    set_vec(5,  0, 0, 0, 0, 0,    100, 1, 0, 0);
    set_vec(6,  0, 0, 0, 0, 0,    100, 1, 0, 0);
    set_vec(7,  0, 0, 0, 0, 0,    100, 1, 0, 0);
    set_vec(8,  0, 0, 0, 0, 0,    100, 0, 1, 0);
    set_vec(9,  0, 0, 0, 0, 0,    100, 0, 1, 0);
    // Downward ramp with prescaler (one change per 3 cycles)
    set_vec(10, 1, 10, 40, 2, 1,  100, 1, 0, 0);
    set_vec(11, 0, 0, 0, 0, 0,    100, 1, 0, 0);
    set_vec(12, 0, 0, 0, 0, 0,    100, 1, 0, 0);
    set_vec(13, 0, 0, 0, 0, 0,    60,  1, 0, 0);
    set_vec(14, 0, 0, 0, 0, 0,    60,  1, 0, 0);
    set_vec(15, 0, 0, 0, 0, 0,    60,  1, 0, 0);
    set_vec(16, 0, 0, 0, 0, 0,    20,  1, 0, 0);
    set_vec(17, 0, 0, 0, 0, 0,    20,  1, 0, 0);
    set_vec(18, 0, 0, 0, 0, 0,    20,  1, 0, 0);
    set_vec(19, 0, 0, 0, 0, 0,    10,  1, 0, 0);
    set_vec(20, 0, 0, 0, 0, 0,    10,  1, 0, 0);
    set_vec(21, 0, 0, 0, 0, 0,    10,  0, 1, 0);
    // Immediate jump with settle 0
    set_vec(22, 1, 32'hDEADBEEF, 0, 5, 0, 32'hDEADBEEF, 1, 0, c_FLUSH);
    set_vec(23, 0, 0, 0, 0, 0,    32'hDEADBEEF, 0, 1, 0);
    set_vec(24, 0, 0, 0, 0, 0,    32'hDEADBEEF, 0, 1, 0);

    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0);
    rst_i = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].ld, vecs[i].tgt, vecs[i].stp, vecs[i].rate, vecs[i].settle);
      tick();
      load_i = 1'b0;
      chk_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].es, vecs[i].ef);
    end

    // Retarget mid-ramp: no jump back, settled stays low until second settle ends
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    drive(1, 1000, 100, 0, 2); tick(); load_i = 0;
    chk_all("rt0", 0, 1, 0, 0);
    tick(); chk_all("rt1", 100, 1, 0, 0);
    tick(); chk_all("rt2", 200, 1, 0, 0);
    tick(); chk_all("rt3", 300, 1, 0, 0);
    drive(1, 0, 150, 0, 2); tick(); load_i = 0;
    chk_all("rt4", 300, 1, 0, 0);
    tick(); chk_all("rt5", 150, 1, 0, 0);
    tick(); chk_all("rt6", 0, 1, 0, 0);
    tick(); chk_all("rt7", 0, 1, 0, 0);
    tick(); chk_all("rt8", 0, 1, 0, 0);
    tick(); chk_all("rt9", 0, 0, 1, 0);

    // Load collides with settle expiry
    drive(1, 5, 0, 0, 2); tick(); load_i = 0;
    chk_all("col0", 5, 1, 0, c_FLUSH);
    tick(); chk_all("col1", 5, 1, 0, 0);
    tick(); chk_all("col2", 5, 1, 0, 0);
    drive(1, 7, 0, 0, 0); tick(); load_i = 0;
    chk_all("col3", 7, 1, 0, c_FLUSH);
    tick(); chk_all("col4", 7, 0, 1, 0);

    // Asynchronous reset mid-ramp, then a normal sequence
    drive(1, 1000, 10, 0, 0); tick(); load_i = 0;
    tick(); tick();
    chk_all("rr0", 7 + 20, 1, 0, 0);
    #2 rst_i = 1'b1;
    #1 chk_all("rr_async", 0, 0, 0, 0);
    tick();
    rst_i = 1'b0;
    drive(1, 20, 10, 0, 0); tick(); load_i = 0;
    chk_all("rr1", 0, 1, 0, 0);
    tick(); chk_all("rr2", 10, 1, 0, 0);
    tick(); chk_all("rr3", 20, 1, 0, 0);
    tick(); chk_all("rr4", 20, 0, 1, 0);

    // Randomized loads against the reference model
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    m_a = 0; m_b = 0; m_s = 0; m_f = 0;
    sched.delete();
    for (int c = 0; c < 2000; c++) begin
      ld = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0, 1:    t = 32'hFFFF_0000 | ($urandom() & 32'h0000_FFFF);
        2:       t = $urandom();
        3:       t = m_a;
        default: t = $urandom_range(0, 1000);
      endcase
      d  = (t > m_a) ? t - m_a : m_a - t;
      s  = d / $urandom_range(1, 12) + $urandom_range(0, 50);
      if ($urandom_range(0, 5) == 0) s = 0;
      r  = 16'($urandom_range(0, 3));
      st = 24'($urandom_range(0, 5));
      drive(ld, t, s, r, st);
      model_edge(ld, t, s, r, st);
      tick();
      load_i = 1'b0;
      chk_all($sformatf("rnd%0d", c), m_a, m_b, m_s, m_f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
